// File: rtl/count_pkg.sv
// Shared constants and encodings for the counter control path.
package count_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic        UP_DOWN_RST = 1'b1;
    localparam int unsigned COUNT_MOD   = 10;

endpackage

// File: rtl/debounce.sv
// Two-flop synchroniser, consecutive-mismatch debouncer and rising-edge detector for one button.
module debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic CLK,
    input  logic RSTn,
    input  logic IN,
    output logic OUT,
    output logic RISE
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic          deb_q;
    logic          deb_d1_q;

    // Bring the raw button into the clock domain.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], IN};
        end
    end

    // Accept a level change only after an unbroken run of mismatching cycles.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            cnt_q <= '0;
            deb_q <= 1'b0;
        end else if (sync_q[1] != deb_q) begin
            if (cnt_q == CNT_LAST) begin
                deb_q <= ~deb_q;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end else begin
            cnt_q <= '0;
        end
    end

    // Delayed debounced level for edge detection.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            deb_d1_q <= 1'b0;
        end else begin
            deb_d1_q <= deb_q;
        end
    end

    assign OUT  = deb_q;
    assign RISE = deb_q & ~deb_d1_q;

endmodule

// File: rtl/count_ctrl.sv
// Turns run/stop and direction pushbuttons into ENABLE pulses and UP_DOWN for the mod-10 counter.
module count_ctrl
    import count_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned PRESCALE        = 5
) (
    input  logic CLK,
    input  logic RSTn,
    input  logic BTN_RUN,
    input  logic BTN_DIR,
    output logic ENABLE,
    output logic UP_DOWN,
    output logic RUNNING
);

    localparam int unsigned   PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic          run_rise;
    logic          dir_rise;
    logic          run_lvl_unused;
    logic          dir_lvl_unused;

    state_t        state_q;
    state_t        state_d;
    logic [PW-1:0] pre_q;
    logic [PW-1:0] pre_d;
    logic          enable_q;
    logic          enable_d;
    logic          up_q;
    logic          up_d;

    debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_run (
        .CLK  (CLK),
        .RSTn (RSTn),
        .IN   (BTN_RUN),
        .OUT  (run_lvl_unused),
        .RISE (run_rise)
    );

    debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_dir (
        .CLK  (CLK),
        .RSTn (RSTn),
        .IN   (BTN_DIR),
        .OUT  (dir_lvl_unused),
        .RISE (dir_rise)
    );

    // Next state: run toggle, prescaler phase, enable pulse and direction toggle.
    always_comb begin
        state_d  = state_q;
        pre_d    = pre_q;
        enable_d = 1'b0;
        up_d     = up_q ^ dir_rise;
        case (state_q)
            ST_IDLE: begin
                pre_d = '0;
                if (run_rise) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (run_rise) begin
                    state_d = ST_IDLE;
                    pre_d   = '0;
                end else begin
                    enable_d = (pre_q == PRE_LAST);
                    pre_d    = (pre_q == PRE_LAST) ? '0 : pre_q + PW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                pre_d   = '0;
            end
        endcase
    end

    // State, prescaler and output registers.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q  <= ST_IDLE;
            pre_q    <= '0;
            enable_q <= 1'b0;
            up_q     <= UP_DOWN_RST;
        end else begin
            state_q  <= state_d;
            pre_q    <= pre_d;
            enable_q <= enable_d;
            up_q     <= up_d;
        end
    end

    assign ENABLE  = enable_q;
    assign UP_DOWN = up_q;
    assign RUNNING = (state_q == ST_RUN);

endmodule

// File: tb/tb_count_ctrl.sv
// Randomised scoreboard bench for count_ctrl (PRESCALE=5 and PRESCALE=1 instances).
module tb_count_ctrl;

    localparam int D = 4;

    logic clk;
    logic rst_n;
    logic btn_run;
    logic btn_dir;
    logic enable;
    logic up_down;
    logic running;
    logic enable1;
    logic up_down1;
    logic running1;

    int checks;
    int failures;

    typedef struct packed {
        logic en5;
        logic en1;
        logic up;
        logic run;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state
    bit m_run;
    bit m_up;
    int m_age;
    bit rise[2];
    bit deb[2];
    bit pipe[2][2];
    bit shist[2][16];
    int nval[2];

    count_ctrl #(.DEBOUNCE_CYCLES(D), .PRESCALE(5)) dut (
        .CLK     (clk),
        .RSTn    (rst_n),
        .BTN_RUN (btn_run),
        .BTN_DIR (btn_dir),
        .ENABLE  (enable),
        .UP_DOWN (up_down),
        .RUNNING (running)
    );

    count_ctrl #(.DEBOUNCE_CYCLES(D), .PRESCALE(1)) dut1 (
        .CLK     (clk),
        .RSTn    (rst_n),
        .BTN_RUN (btn_run),
        .BTN_DIR (btn_dir),
        .ENABLE  (enable1),
        .UP_DOWN (up_down1),
        .RUNNING (running1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0b exp=%0b", name, $time, act, exp);
        end
    endfunction

    function automatic void model_reset();
        m_run = 1'b0;
        m_up  = 1'b1;
        m_age = 0;
        for (int b = 0; b < 2; b++) begin
            rise[b]    = 1'b0;
            deb[b]     = 1'b0;
            pipe[b][0] = 1'b0;
            pipe[b][1] = 1'b0;
            nval[b]    = 0;
            for (int i = 0; i < 16; i++) shist[b][i] = 1'b0;
        end
    endfunction

    // A level is accepted once the last D synchronised samples all disagree with it.
    function automatic void deb_step(int b, bit raw);
        bit s;
        bit all;
        s          = pipe[b][0];
        pipe[b][0] = pipe[b][1];
        pipe[b][1] = raw;
        for (int i = 15; i > 0; i--) shist[b][i] = shist[b][i-1];
        shist[b][0] = s;
        if (nval[b] < 16) nval[b]++;
        all = (nval[b] >= D);
        for (int i = 0; i < D; i++) if (shist[b][i] == deb[b]) all = 1'b0;
        rise[b] = 1'b0;
        if (all) begin
            deb[b]  = ~deb[b];
            rise[b] = deb[b];
        end
    endfunction

    // One clock edge of the reference model; pushes the expected registered outputs.
    function automatic void model_step(bit rn, bit br, bit bd);
        exp_t e;
        if (!rn) begin
            model_reset();
            e = '{en5: 1'b0, en1: 1'b0, up: 1'b1, run: 1'b0};
            exp_q.push_back(e);
            return;
        end
        e.en5 = 1'b0;
        e.en1 = 1'b0;
        if (rise[0]) begin
            m_run = ~m_run;
            m_age = 0;
        end else if (m_run) begin
            m_age++;
            e.en5 = ((m_age % 5) == 0);
            e.en1 = 1'b1;
        end
        if (rise[1]) m_up = ~m_up;
        e.up  = m_up;
        e.run = m_run;
        deb_step(0, br);
        deb_step(1, bd);
        exp_q.push_back(e);
    endfunction

    // Scoreboard monitor: compare on the falling edge, away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("enable_p5", enable, e.en5);
            chk("running_p5", running, e.run);
            chk("up_down_p5", up_down, e.up);
            chk("enable_p1", enable1, e.en1);
            chk("running_p1", running1, e.run);
            chk("up_down_p1", up_down1, e.up);
        end
    end

    task automatic cyc(input bit br, input bit bd);
        @(negedge clk);
        rst_n   = 1'b1;
        btn_run = br;
        btn_dir = bd;
        @(posedge clk);
        model_step(rst_n, br, bd);
    endtask

    task automatic run_n(input int n, input bit br, input bit bd);
        for (int i = 0; i < n; i++) cyc(br, bd);
    endtask

    // Reset for n cycles; when mid is set it is asserted between clock edges and checked at once.
    task automatic reset_cycles(input int n, input bit mid, input bit hold_run);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            btn_run = hold_run ? 1'b1 : 1'(($urandom() & 1));
            btn_dir = 1'(($urandom() & 1));
            if (i == 0 && mid) begin
                #2;
                rst_n = 1'b0;
                #1;
                chk("async_rst_enable", enable, 1'b0);
                chk("async_rst_running", running, 1'b0);
                chk("async_rst_up_down", up_down, 1'b1);
                chk("async_rst_enable_p1", enable1, 1'b0);
            end else begin
                rst_n = 1'b0;
            end
            @(posedge clk);
            model_step(rst_n, btn_run, btn_dir);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t got=timeout exp=finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int len;
        bit br;
        bit bd;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        btn_run  = 1'b0;
        btn_dir  = 1'b0;
        model_reset();

        reset_cycles(2, 1'b0, 1'b0);
        run_n(20, 1'b0, 1'b0);

        // Clean run press, pulses, then stop
        run_n(10, 1'b1, 1'b0);
        run_n(30, 1'b0, 1'b0);
        run_n(10, 1'b1, 1'b0);
        run_n(15, 1'b0, 1'b0);

        // Bounce rejection followed by a real press
        cyc(1'b1, 1'b0); cyc(1'b0, 1'b0);
        run_n(2, 1'b1, 1'b0); cyc(1'b0, 1'b0);
        run_n(3, 1'b1, 1'b0); cyc(1'b0, 1'b0);
        run_n(10, 1'b0, 1'b0);
        run_n(6, 1'b1, 1'b0);
        run_n(12, 1'b0, 1'b0);

        // Direction change while running
        run_n(8, 1'b0, 1'b1);
        run_n(20, 1'b0, 1'b0);

        // Stop, restore UP, then simultaneous press from IDLE
        run_n(8, 1'b1, 1'b0);
        run_n(10, 1'b0, 1'b0);
        run_n(8, 1'b0, 1'b1);
        run_n(10, 1'b0, 1'b0);
        run_n(8, 1'b1, 1'b1);
        run_n(15, 1'b0, 1'b0);

        // Mid-run asynchronous reset with run button held through release
        reset_cycles(2, 1'b1, 1'b1);
        run_n(10, 1'b1, 1'b0);
        run_n(15, 1'b0, 1'b0);

        // Random button activity with occasional resets
        for (int s = 0; s < 400; s++) begin
            if ($urandom_range(0, 49) == 0) begin
                reset_cycles($urandom_range(1, 3), 1'b1, 1'b0);
            end else begin
                len = $urandom_range(1, 8);
                br  = 1'(($urandom() & 1));
                bd  = 1'(($urandom() & 1));
                run_n(len, br, bd);
            end
        end

        run_n(5, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/count_ctrl.md
# count_ctrl

Control stage directly upstream of the mod-10 up/down counter. Converts two raw pushbuttons (run/stop, direction) into the counter's ENABLE and UP_DOWN inputs. Each button is synchronised and debounced, and its rising edge toggles a state bit. While running, a prescaler emits a one-cycle ENABLE pulse every PRESCALE clocks, so the counter advances at a visible rate.

## Interface
- DEBOUNCE_CYCLES, 4: consecutive cycles a synchronised button must differ from its debounced level before the change is accepted (≥1; board builds override to ~500000).
- PRESCALE, 5: clock cycles per ENABLE pulse while running (≥1).
- CLK  input  1  system clock, rising edge.
- RSTn  input  1  one clock; reset is asynchronous and active-low.
- BTN_RUN  input  1  raw run/stop pushbutton, asynchronous, active-high.
- BTN_DIR  input  1  raw direction pushbutton, asynchronous, active-high.
- ENABLE  output  1  count-enable to counter, registered, one-cycle pulses.
- UP_DOWN  output  1  direction to counter, registered; 1 = up, 0 = down.
- RUNNING  output  1  registered run state, for LED.

## Operation
- Reset (RSTn=0, async): ENABLE=0, UP_DOWN=1, RUNNING=0, FSM=IDLE, prescaler=0, synchroniser flops=0, debounced levels=0, debounce counters=0.
- Synchroniser: 2 flops per button, no logic between them.
- Debounce, per button:
  - If synced ≠ debounced: counter increments.
  - Once DEBOUNCE_CYCLES consecutive mismatch cycles have accumulated, debounced flips and counter clears.
  - Any match cycle clears the counter. Glitches shorter than DEBOUNCE_CYCLES are rejected.
- Edge detect: rise = debounced & ~debounced_q. Falling edges are ignored.
- FSM states IDLE, RUN:
  - IDLE→RUN on run_rise. RUN→IDLE on run_rise.
  - RUNNING=1 exactly in RUN.
- Prescaler, active in RUN only:
  - Counts 0..PRESCALE-1 and wraps to 0.
  - ENABLE=1 in the cycle after the prescaler registers PRESCALE-1.
  - Entering RUN clears the prescaler to 0. Entering IDLE clears it to 0 and forces ENABLE=0 on the same edge.
  - With PRESCALE=1, ENABLE is held high continuously in RUN.
- Direction: dir_rise toggles UP_DOWN in any state. It does not disturb the prescaler phase.
- Simultaneous run_rise and dir_rise: both take effect on the same edge.
- Both buttons held: each produces exactly one toggle per press (edge-based, no auto-repeat).

## Timing
- Button-to-state latency: raw level stable before edge 0 → RUNNING/UP_DOWN toggle at edge DEBOUNCE_CYCLES+2 (2 sync + DEBOUNCE_CYCLES debounce + 1 state register, counting edge 0). With defaults, 6 cycles after the first sampling edge.
- First ENABLE pulse: PRESCALE cycles after RUNNING rises, then one pulse every PRESCALE cycles.
- ENABLE falls on the same edge RUNNING falls. The counter never sees an ENABLE pulse after RUNNING=0.
- Reset mid-operation: all outputs return to reset values asynchronously. After RSTn rises, a button still held is re-debounced from 0 and produces a toggle after the full latency.
- All outputs change only on CLK rising edges or async reset. No combinational path from inputs to outputs.

## Structure
- Shared include/package count_pkg:
  - FSM encodings ST_IDLE=1'b0, ST_RUN=1'b1.
  - UP_DOWN_RST=1'b1.
  - Counter modulo constant (10), shared with the counter.
- Sub-module debounce (parameter DEBOUNCE_CYCLES; ports CLK, RSTn, IN, OUT, RISE):
  - Contains the 2-flop synchroniser, the mismatch counter ($clog2(DEBOUNCE_CYCLES+1) bits) and the edge detector.
  - Instantiated twice.
- Top count_ctrl: FSM, prescaler ($clog2(PRESCALE) bits, min 1), UP_DOWN toggle register.

## Test plan
- Reset: RSTn=0 for 2T with buttons toggling → ENABLE=0, UP_DOWN=1, RUNNING=0 throughout. After release with buttons low, outputs unchanged for 20T.
- Clean run press: BTN_RUN high for 10T (defaults) → RUNNING=1 six edges after first sample. ENABLE pulses 1 cycle wide every 5T, first one 5T after RUNNING rises. Second press → RUNNING=0 and ENABLE=0 on the same edge.
- Bounce rejection: BTN_RUN pulses of 1, 2 and 3 cycles separated by 1-cycle lows → RUNNING stays 0. A following 4+ cycle stable high → exactly one toggle.
- Direction while running: RUN active, BTN_DIR pressed → UP_DOWN 1→0 at latency 6. ENABLE pulse spacing stays exactly 5T across the change.
- Simultaneous: both buttons rise on the same cycle from IDLE/UP → RUNNING=1 and UP_DOWN=0 on the same edge.
- Edge cases: PRESCALE=1 → ENABLE constantly 1 in RUN. Async reset asserted mid-RUN between clock edges → ENABLE and RUNNING drop immediately without waiting for CLK.
